// File: rtl/seq_cla_mult_ctrl.sv
// seq_cla_mult_ctrl
// Sequential shift-and-add unsigned multiplier that reuses one N-bit
// carry-lookahead adder (carry-in 0) for N iterations and produces a 2N-bit
// product. Operands arrive over a valid/ready handshake and the product
// leaves over another valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands a/b valid
//   in_ready   block can accept operands (high only in IDLE)
//   a          N-bit unsigned multiplicand
//   b          N-bit unsigned multiplier
//   out_valid  product p valid (high only in DONE)
//   out_ready  consumer accepts p
//   p          2N-bit product, held until the next product is loaded
//   busy       high while iterating (RUN)
//
// Optional build macro: SEQ_MULT_EARLY_TERM_EN
//   When defined, a RUN cycle whose remaining multiplier bits are all zero
//   skips the add, shifts the accumulator right by the remaining count in
//   one step and finishes. When undefined, latency is always N cycles.
module seq_cla_mult_ctrl #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // N-bit carry-lookahead add with zero carry-in; returns {cout, sum}.
  function automatic logic [N:0] cla_add(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N-1:0] g;
    logic [N-1:0] pr;
    logic [N:0]   c;
    g    = x & y;
    pr   = x ^ y;
    c[0] = 1'b0;
    for (int i = 0; i < N; i++) begin
      c[i+1] = g[i] | (pr[i] & c[i]);
    end
    return {c[N], pr ^ c[N-1:0]};
  endfunction

  state_t           state_q, state_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [N-1:0]     acc_hi_q, acc_hi_d;
  logic [N-1:0]     acc_lo_q, acc_lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   p_q, p_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [N-1:0]     addend_s;
  logic [N:0]       add_s;
  logic [2*N-1:0]   step_acc_s;

  // Single shared adder: acc_hi plus multiplicand gated by the current multiplier LSB.
  always_comb begin
    addend_s   = acc_lo_q[0] ? mcand_q : {N{1'b0}};
    add_s      = cla_add(acc_hi_q, addend_s);
    // {cout, sum, acc_lo} >> 1: cout lands in acc_hi[N-1], LSB drops off.
    step_acc_s = {add_s, acc_lo_q[N-1:1]};
  end

`ifdef SEQ_MULT_EARLY_TERM_EN
  logic [N-1:0]   pend_mask_s;
  logic           skip_s;
  logic [2*N-1:0] skip_acc_s;

  // Zero-detect on the unconsumed multiplier bits and the matching barrel shift.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      pend_mask_s[i] = (i < int'(cnt_q));
    end
    skip_s     = ((acc_lo_q & pend_mask_s) == {N{1'b0}});
    skip_acc_s = {acc_hi_q, acc_lo_q} >> cnt_q;
  end
`endif

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          mcand_d  = a;
          acc_hi_d = {N{1'b0}};
          acc_lo_d = b;
          cnt_d    = CW'(N);
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
`ifdef SEQ_MULT_EARLY_TERM_EN
        if (skip_s) begin
          {acc_hi_d, acc_lo_d} = skip_acc_s;
          cnt_d                = {CW{1'b0}};
          p_d                  = skip_acc_s;
          state_d              = S_DONE;
        end else if (cnt_q == CW'(1)) begin
          {acc_hi_d, acc_lo_d} = step_acc_s;
          cnt_d                = cnt_q - CW'(1);
          p_d                  = step_acc_s;
          state_d              = S_DONE;
        end else begin
          {acc_hi_d, acc_lo_d} = step_acc_s;
          cnt_d                = cnt_q - CW'(1);
          state_d              = S_RUN;
        end
`else
        {acc_hi_d, acc_lo_d} = step_acc_s;
        cnt_d                = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          p_d     = step_acc_s;
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
`endif
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Handshake/status flags are registered copies of the next state.
    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d == S_RUN);
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mcand_q     <= {N{1'b0}};
      acc_hi_q    <= {N{1'b0}};
      acc_lo_q    <= {N{1'b0}};
      cnt_q       <= {CW{1'b0}};
      p_q         <= {(2*N){1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign p         = p_q;

endmodule

// File: tb/tb_seq_cla_mult_ctrl.sv
// Testbench for seq_cla_mult_ctrl: one N=4 and one N=8 instance share a
// clock and reset; a select bit routes the stimulus to one of them at a time.
module tb_seq_cla_mult_ctrl;

`ifdef SEQ_MULT_EARLY_TERM_EN
  localparam bit ET_EN = 1'b1;
`else
  localparam bit ET_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid_t;
  logic        out_ready_t;
  logic [7:0]  a_t;
  logic [7:0]  b_t;
  logic        sel8;

  logic        iv4, or4, ir4, ov4, busy4;
  logic        iv8, or8, ir8, ov8, busy8;
  logic [7:0]  p4;
  logic [15:0] p8;

  logic        in_ready_o, out_valid_o, busy_o;
  logic [15:0] p_o;

  int n_cmp;
  int n_fail;

  assign iv4 = in_valid_t & ~sel8;
  assign iv8 = in_valid_t & sel8;
  assign or4 = out_ready_t & ~sel8;
  assign or8 = out_ready_t & sel8;

  assign in_ready_o  = sel8 ? ir8 : ir4;
  assign out_valid_o = sel8 ? ov8 : ov4;
  assign busy_o      = sel8 ? busy8 : busy4;
  assign p_o         = sel8 ? p8 : {8'h00, p4};

  seq_cla_mult_ctrl #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .a(a_t[3:0]), .b(b_t[3:0]), .out_valid(ov4), .out_ready(or4),
    .p(p4), .busy(busy4)
  );

  seq_cla_mult_ctrl #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a_t), .b(b_t), .out_valid(ov8), .out_ready(or8),
    .p(p8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected cycles from accept to out_valid, from the latency rules.
  function automatic int exp_lat(input int w, input int bv);
    int m;
    int et;
    m = -1;
    for (int i = 0; i < w; i++) begin
      if (bv[i]) m = i;
    end
    if (m < 0) et = 1;
    else if (m < w - 1) et = m + 2;
    else et = w;
    return ET_EN ? et : w;
  endfunction

  // Present operands and wait (bounded) for the accept edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, output int waited);
    a_t = a;
    b_t = b;
    in_valid_t = 1'b1;
    waited = 0;
    while (!in_ready_o && waited < 40) begin
      tick();
      waited++;
    end
    chk("accept_ready", {31'd0, in_ready_o}, 32'd1);
    tick();
    in_valid_t = 1'b0;
  endtask

  // Follow one operation from accept to the output handshake.
  task automatic collect(input logic [15:0] exp_p, input int lat_exp, input int stall,
                         input bit chain, input logic [7:0] na, input logic [7:0] nb);
    int lat;
    lat = 0;
    out_ready_t = (stall == 0);
    while (!out_valid_o && lat < 40) begin
      chk("busy_run", {31'd0, busy_o}, 32'd1);
      chk("in_ready_run", {31'd0, in_ready_o}, 32'd0);
      tick();
      lat++;
    end
    chk("latency", lat, lat_exp);
    chk("product", {16'd0, p_o}, {16'd0, exp_p});
    chk("busy_done", {31'd0, busy_o}, 32'd0);
    chk("in_ready_done", {31'd0, in_ready_o}, 32'd0);
    if (chain) begin
      a_t = na;
      b_t = nb;
      in_valid_t = 1'b1;
    end
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_valid", {31'd0, out_valid_o}, 32'd1);
      chk("stall_p", {16'd0, p_o}, {16'd0, exp_p});
      chk("stall_in_ready", {31'd0, in_ready_o}, 32'd0);
    end
    out_ready_t = 1'b1;
    tick();
    chk("hs_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("hs_in_ready", {31'd0, in_ready_o}, 32'd1);
    chk("hs_busy", {31'd0, busy_o}, 32'd0);
    chk("hs_p_hold", {16'd0, p_o}, {16'd0, exp_p});
  endtask

  initial begin
    int w;
    int stall;
    logic [7:0] ra, rb;
    n_cmp = 0;
    n_fail = 0;
    sel8 = 1'b0;
    in_valid_t = 1'b0;
    out_ready_t = 1'b1;
    a_t = 8'd0;
    b_t = 8'd0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state for both instances
    for (int k = 0; k < 2; k++) begin
      sel8 = (k == 1);
      #1;
      chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_p", {16'd0, p_o}, 32'd0);
    end
    sel8 = 1'b0;

    // 13*11 with out_ready high
    issue(8'd13, 8'd11, w);
    collect(16'd143, exp_lat(4, 11), 0, 1'b0, 8'd0, 8'd0);

    // Back-to-back 15*15 then 0*9, second operands offered while in DONE
    issue(8'd15, 8'd15, w);
    collect(16'd225, exp_lat(4, 15), 0, 1'b1, 8'd0, 8'd9);
    issue(8'd0, 8'd9, w);
    chk("accept_gap", w, 0);
    collect(16'd0, exp_lat(4, 9), 0, 1'b0, 8'd0, 8'd0);

    // Backpressure: 7*6 held 5 cycles
    issue(8'd7, 8'd6, w);
    collect(16'd42, exp_lat(4, 6), 5, 1'b0, 8'd0, 8'd0);

    // Reset on the second RUN cycle discards the operation
    issue(8'd9, 8'd9, w);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_rst_p", {16'd0, p_o}, 32'd0);
    for (int c = 0; c < 8; c++) begin
      chk("mid_rst_no_valid", {31'd0, out_valid_o}, 32'd0);
      tick();
    end
    issue(8'd3, 8'd5, w);
    collect(16'd15, exp_lat(4, 5), 0, 1'b0, 8'd0, 8'd0);

    // Early-termination corner operands (latency follows the build)
    issue(8'd5, 8'd0, w);
    collect(16'd0, exp_lat(4, 0), 0, 1'b0, 8'd0, 8'd0);
    issue(8'd12, 8'd1, w);
    collect(16'd12, exp_lat(4, 1), 0, 1'b0, 8'd0, 8'd0);
    issue(8'd3, 8'd8, w);
    collect(16'd24, exp_lat(4, 8), 0, 1'b0, 8'd0, 8'd0);

    // Random N=4
    for (int r = 0; r < 100; r++) begin
      ra = 8'($urandom_range(0, 15));
      rb = 8'($urandom_range(0, 15));
      stall = int'($urandom_range(0, 2));
      issue(ra, rb, w);
      collect(16'(int'(ra) * int'(rb)), exp_lat(4, int'(rb)), stall, 1'b0, 8'd0, 8'd0);
    end

    // N=8: full-scale operands then random pairs
    sel8 = 1'b1;
    #1;
    issue(8'd255, 8'd255, w);
    collect(16'd65025, exp_lat(8, 255), 0, 1'b0, 8'd0, 8'd0);
    for (int r = 0; r < 1000; r++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      stall = int'($urandom_range(0, 2));
      issue(ra, rb, w);
      collect(16'(int'(ra) * int'(rb)), exp_lat(8, int'(rb)), stall, 1'b0, 8'd0, 8'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
